apb_multi_timer: RTL

- Parametrised successor to the single-channel APB timer: NUM_CH independent down-counters behind one APB3 slave, each with prescaler, external-input gate/clock modes, one-shot or periodic mode, and its own interrupt.
- Sits on the peripheral APB bus next to the existing timer.
- Drives per-channel interrupt lines plus an OR-combined line to the interrupt controller.

---
 rtl/apb_multi_timer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/apb_multi_timer.sv
// Multi-channel APB3 down-counter timer: NUM_CH channels with prescaler, external
// gate/clock modes, one-shot or periodic reload, and per-channel plus combined interrupts.
module apb_multi_timer #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic [11:2]       paddr,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        ecorevnum,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [NUM_CH-1:0] extin,
  output logic [NUM_CH-1:0] timerint,
  output logic              timerint_any
);

  localparam logic [9:0] INTALL_A = 10'h040;
  localparam logic [9:0] ID_A     = 10'h3F8;

  logic              access;
  logic              ch_hit;
  logic              intall_hit;
  logic              id_hit;
  logic              wr_en;
  logic [31:0]       ctrl_rd   [NUM_CH];
  logic [31:0]       value_rd  [NUM_CH];
  logic [31:0]       reload_rd [NUM_CH];
  logic [NUM_CH-1:0] intstat_all;
  logic [NUM_CH-1:0] tint;
  logic              unused;

  // Channel windows occupy 0x000-0x0FF; only indices below NUM_CH decode.
  assign ch_hit     = ({24'd0, paddr[11:4]} < 32'(NUM_CH));
  assign intall_hit = (paddr == INTALL_A);
  assign id_hit     = (paddr == ID_A);
  assign access     = psel & penable;
  assign wr_en      = access & pwrite & ch_hit;

  assign pready       = 1'b1;
  assign pslverr      = access & ~(ch_hit | intall_hit | id_hit);
  assign timerint     = tint;
  assign timerint_any = |tint;
  assign unused       = ^pwdata;

  genvar n;
  for (n = 0; n < NUM_CH; n++) begin : g_ch
    logic               en, gate, eclk, inten, oneshot, intstat, tint_r;
    logic [PRESC_W-1:0] presc, pcnt;
    logic [CNT_W-1:0]   value, reload;
    logic               ext_p0, ext_p1, ext_p2;
    logic               sel, wr_ctrl, wr_value, wr_reload, wr_int;
    logic               src, tick, tick_eff, uflow;

    assign sel       = (paddr[11:4] == 8'(n));
    assign wr_ctrl   = wr_en & sel & (paddr[3:2] == 2'd0);
    assign wr_value  = wr_en & sel & (paddr[3:2] == 2'd1);
    assign wr_reload = wr_en & sel & (paddr[3:2] == 2'd2);
    assign wr_int    = wr_en & sel & (paddr[3:2] == 2'd3);

    // ext_p1 is the synchronised level; ext_p1 & ~ext_p2 is its rising edge.
    assign src      = en & (eclk ? (ext_p1 & ~ext_p2) : 1'b1) & (~gate | ext_p1);
    assign tick     = src & (pcnt == presc);
    assign tick_eff = tick & ~(wr_ctrl & ~pwdata[0]);
    assign uflow    = tick_eff & (value == '0);

    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        en      <= 1'b0;
        gate    <= 1'b0;
        eclk    <= 1'b0;
        inten   <= 1'b0;
        oneshot <= 1'b0;
        presc   <= '0;
        pcnt    <= '0;
        value   <= '0;
        reload  <= '0;
        intstat <= 1'b0;
        tint_r  <= 1'b0;
        ext_p0  <= 1'b0;
        ext_p1  <= 1'b0;
        ext_p2  <= 1'b0;
      end else begin
        ext_p0 <= extin[n];
        ext_p1 <= ext_p0;
        ext_p2 <= ext_p1;

        if (wr_ctrl)  pcnt <= '0;
        else if (src) pcnt <= tick ? '0 : pcnt + PRESC_W'(1);

        if (wr_ctrl) begin
          en      <= pwdata[0];
          gate    <= pwdata[1];
          eclk    <= pwdata[2];
          inten   <= pwdata[3];
          oneshot <= pwdata[4];
          presc   <= pwdata[8 +: PRESC_W];
        end
        // One-shot expiry disables the channel even over a simultaneous CTRL write.
        if (uflow & oneshot) en <= 1'b0;

        if (wr_value)      value <= pwdata[CNT_W-1:0];
        else if (tick_eff) value <= (value != '0) ? value - CNT_W'(1) : (oneshot ? '0 : reload);

        if (wr_reload) reload <= pwdata[CNT_W-1:0];

        if (uflow)                  intstat <= 1'b1;
        else if (wr_int & pwdata[0]) intstat <= 1'b0;

        tint_r <= intstat & inten;
      end
    end

    assign ctrl_rd[n]     = 32'({presc, 3'b000, oneshot, inten, eclk, gate, en});
    assign value_rd[n]    = 32'(value);
    assign reload_rd[n]   = 32'(reload);
    assign intstat_all[n] = intstat;
    assign tint[n]        = tint_r;
  end

  always_comb begin
    prdata = '0;
    if (psel) begin
      if (id_hit) begin
        prdata = {20'h0, ecorevnum, 4'(NUM_CH), 4'h1};
      end else if (intall_hit) begin
        prdata = 32'(intstat_all);
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (paddr[11:4] == 8'(i)) begin
            case (paddr[3:2])
              2'd0:    prdata = ctrl_rd[i];
              2'd1:    prdata = value_rd[i];
              2'd2:    prdata = reload_rd[i];
              default: prdata = 32'(intstat_all[i]);
            endcase
          end
        end
      end
    end
  end

endmodule
